// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, FSM state encoding and byte classification for the key decoder.
// Pure definitions: no latency, no flow control.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_LEFT   = 8'h6B;
  localparam logic [7:0] PS2_RIGHT  = 8'h74;
  localparam logic [7:0] PS2_UP     = 8'h75;
  localparam logic [7:0] PS2_DOWN   = 8'h72;

  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Keyboard status/ack replies and the pause prefix never form a key event.
  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Set-2 scan code to ASCII lookup (letters, digits, space, enter, backspace); 0 means unmapped.
// Purely combinational, no flow control.
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (code)
      8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63; 8'h23: base = 8'h64;
      8'h24: base = 8'h65; 8'h2B: base = 8'h66; 8'h34: base = 8'h67; 8'h33: base = 8'h68;
      8'h43: base = 8'h69; 8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F; 8'h4D: base = 8'h70;
      8'h15: base = 8'h71; 8'h2D: base = 8'h72; 8'h1B: base = 8'h73; 8'h2C: base = 8'h74;
      8'h3C: base = 8'h75; 8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
      8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
      8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32; 8'h26: base = 8'h33;
      8'h25: base = 8'h34; 8'h2E: base = 8'h35; 8'h36: base = 8'h36; 8'h3D: base = 8'h37;
      8'h3E: base = 8'h38; 8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase
    ascii = base;
    // Shift only affects letters; digits and control characters pass unchanged.
    if (shift && (base >= 8'h61) && (base <= 8'h7A)) begin
      ascii = base - ASCII_CASE_OFFSET;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 make/break/extended byte stream into arrow/shift levels and ASCII strobes.
// Outputs registered 1 clk after the final byte; no backpressure, every rx_valid byte is consumed.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_left,
  output logic       key_right,
  output logic       key_up,
  output logic       key_down,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic       shift_held
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d, right_q, right_d, up_q, up_d, down_q, down_d;
  logic             lshift_q, lshift_d, rshift_q, rshift_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             ascii_valid_q, ascii_valid_d;
  logic [7:0]       lut_ascii;

  ps2_scan_to_ascii u_lut (
    .code  (rx_data),
    .shift (lshift_q | rshift_q),
    .ascii (lut_ascii)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    right_d       = right_q;
    up_d          = up_q;
    down_d        = down_q;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    ascii_d       = ascii_q;
    ascii_valid_d = 1'b0;

    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (!is_ignored_byte(rx_data)) begin
            if (rx_data == PS2_LSHIFT) begin
              lshift_d = 1'b1;
            end else if (rx_data == PS2_RSHIFT) begin
              rshift_d = 1'b1;
            end else if (lut_ascii != 8'h00) begin
              ascii_d       = lut_ascii;
              ascii_valid_d = 1'b1;
            end
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data != PS2_EXT) begin
            state_d = ST_IDLE;
            case (rx_data)
              PS2_LEFT:  left_d  = 1'b1;
              PS2_RIGHT: right_d = 1'b1;
              PS2_UP:    up_d    = 1'b1;
              PS2_DOWN:  down_d  = 1'b1;
              default:   ;
            endcase
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (rx_data == PS2_LSHIFT) begin
            lshift_d = 1'b0;
          end else if (rx_data == PS2_RSHIFT) begin
            rshift_d = 1'b0;
          end
        end
        default: begin
          // Extended break: a repeated prefix here is malformed and falls through the case.
          state_d = ST_IDLE;
          case (rx_data)
            PS2_LEFT:  left_d  = 1'b0;
            PS2_RIGHT: right_d = 1'b0;
            PS2_UP:    up_d    = 1'b0;
            PS2_DOWN:  down_d  = 1'b0;
            default:   ;
          endcase
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      ascii_q       <= 8'h00;
      ascii_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      right_q       <= right_d;
      up_q          <= up_d;
      down_q        <= down_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      ascii_q       <= ascii_d;
      ascii_valid_q <= ascii_valid_d;
    end
  end

  assign key_left    = left_q;
  assign key_right   = right_q;
  assign key_up      = up_q;
  assign key_down    = down_q;
  assign ascii       = ascii_q;
  assign ascii_valid = ascii_valid_q;
  assign shift_held  = lshift_q | rshift_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with a short prefix timeout.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_left, key_right, key_up, key_down;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       shift_held;
  logic [4:0] flags;

  int checks   = 0;
  int failures = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_up      (key_up),
    .key_down    (key_down),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .shift_held  (shift_held)
  );

  always #5 clk = ~clk;

  assign flags = {key_left, key_right, key_up, key_down, shift_held};

  // Called at a negedge; the byte is consumed at the next posedge and the task returns at
  // the following negedge, where registered outputs already reflect it.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b00000); end
    checks++; if (ascii !== 8'h00) begin failures++; $display("FAIL reset_ascii got=%h exp=%h", ascii, 8'h00); end
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL reset_ascii_valid got=%b exp=0", ascii_valid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ext_arrow;
    send_byte(8'hE0);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL ext_prefix_only got=%b exp=%b", flags, 5'b00000); end
    send_byte(8'h6B);
    checks++; if (flags !== 5'b10000) begin failures++; $display("FAIL left_make got=%b exp=%b", flags, 5'b10000); end
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL left_make_no_strobe got=%b exp=0", ascii_valid); end
    send_byte(8'hE0); send_byte(8'h6B);
    checks++; if (flags !== 5'b10000) begin failures++; $display("FAIL left_typematic got=%b exp=%b", flags, 5'b10000); end
    send_byte(8'hE0); send_byte(8'hF0);
    checks++; if (flags !== 5'b10000) begin failures++; $display("FAIL left_break_pending got=%b exp=%b", flags, 5'b10000); end
    send_byte(8'h6B);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL left_break got=%b exp=%b", flags, 5'b00000); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL break_without_make got=%b exp=%b", flags, 5'b00000); end
    // E0 5A is keypad enter: extended, so it must not reach the ASCII path.
    send_byte(8'hE0); send_byte(8'h5A);
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL ext_nonarrow_strobe got=%b exp=0", ascii_valid); end
  endtask

  task automatic test_ascii_shift;
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h61 || ascii_valid !== 1'b1) begin failures++; $display("FAIL a_make ascii=%h vld=%b exp=61/1", ascii, ascii_valid); end
    @(negedge clk);
    checks++; if (ascii !== 8'h61 || ascii_valid !== 1'b0) begin failures++; $display("FAIL a_strobe_one_cycle ascii=%h vld=%b exp=61/0", ascii, ascii_valid); end
    send_byte(8'h12);
    checks++; if (shift_held !== 1'b1 || ascii_valid !== 1'b0) begin failures++; $display("FAIL lshift_make shift=%b vld=%b exp=1/0", shift_held, ascii_valid); end
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h41 || ascii_valid !== 1'b1) begin failures++; $display("FAIL A_upper ascii=%h vld=%b exp=41/1", ascii, ascii_valid); end
    send_byte(8'hF0); send_byte(8'h12);
    checks++; if (shift_held !== 1'b0) begin failures++; $display("FAIL lshift_break got=%b exp=0", shift_held); end
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h61 || ascii_valid !== 1'b1) begin failures++; $display("FAIL a_after_unshift ascii=%h vld=%b exp=61/1", ascii, ascii_valid); end
  endtask

  task automatic test_ascii_table;
    send_byte(8'h29);
    checks++; if (ascii !== 8'h20) begin failures++; $display("FAIL space got=%h exp=20", ascii); end
    send_byte(8'h5A);
    checks++; if (ascii !== 8'h0D) begin failures++; $display("FAIL enter got=%h exp=0d", ascii); end
    send_byte(8'h66);
    checks++; if (ascii !== 8'h08) begin failures++; $display("FAIL backspace got=%h exp=08", ascii); end
    send_byte(8'h45);
    checks++; if (ascii !== 8'h30) begin failures++; $display("FAIL digit0 got=%h exp=30", ascii); end
    send_byte(8'h59);
    checks++; if (flags !== 5'b00001) begin failures++; $display("FAIL rshift_make got=%b exp=%b", flags, 5'b00001); end
    send_byte(8'h1A);
    checks++; if (ascii !== 8'h5A) begin failures++; $display("FAIL Z_upper got=%h exp=5a", ascii); end
    send_byte(8'h16);
    checks++; if (ascii !== 8'h31 || ascii_valid !== 1'b1) begin failures++; $display("FAIL digit1_shift ascii=%h vld=%b exp=31/1", ascii, ascii_valid); end
    send_byte(8'hF0); send_byte(8'h59);
    checks++; if (shift_held !== 1'b0) begin failures++; $display("FAIL rshift_break got=%b exp=0", shift_held); end
    send_byte(8'hAA);
    checks++; if (ascii !== 8'h31 || ascii_valid !== 1'b0) begin failures++; $display("FAIL ignored_aa ascii=%h vld=%b exp=31/0", ascii, ascii_valid); end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (ascii !== 8'h31 || ascii_valid !== 1'b0) begin failures++; $display("FAIL letter_break ascii=%h vld=%b exp=31/0", ascii, ascii_valid); end
  endtask

  task automatic test_timeout;
    // One cycle short of the timeout the prefix is still pending.
    send_byte(8'hE0);
    repeat (15) @(negedge clk);
    send_byte(8'h75);
    checks++; if (flags !== 5'b00100) begin failures++; $display("FAIL prefix_before_timeout got=%b exp=%b", flags, 5'b00100); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL up_break got=%b exp=%b", flags, 5'b00000); end
    send_byte(8'hE0);
    repeat (16) @(negedge clk);
    send_byte(8'h75);
    checks++; if (flags !== 5'b00000 || ascii_valid !== 1'b0) begin failures++; $display("FAIL prefix_timeout flags=%b vld=%b exp=00000/0", flags, ascii_valid); end
  endtask

  task automatic test_back_to_back;
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0);
    send_byte(8'h74); send_byte(8'hE0); send_byte(8'h72);
    checks++; if (flags !== 5'b01110) begin failures++; $display("FAIL b2b_make got=%b exp=%b", flags, 5'b01110); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL b2b_break got=%b exp=%b", flags, 5'b00000); end
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h61 || ascii_valid !== 1'b1) begin failures++; $display("FAIL b2b_first ascii=%h vld=%b exp=61/1", ascii, ascii_valid); end
    send_byte(8'h32);
    checks++; if (ascii !== 8'h62 || ascii_valid !== 1'b1) begin failures++; $display("FAIL b2b_second ascii=%h vld=%b exp=62/1", ascii, ascii_valid); end
    @(negedge clk);
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL b2b_strobe_end got=%b exp=0", ascii_valid); end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hE0); send_byte(8'h6B); send_byte(8'h12);
    checks++; if (flags !== 5'b10001) begin failures++; $display("FAIL pre_reset_held got=%b exp=%b", flags, 5'b10001); end
    send_byte(8'hE0); send_byte(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (flags !== 5'b00000 || ascii !== 8'h00 || ascii_valid !== 1'b0) begin failures++; $display("FAIL mid_reset flags=%b ascii=%h vld=%b exp=00000/00/0", flags, ascii, ascii_valid); end
    send_byte(8'h74);
    checks++; if (flags !== 5'b00000 || ascii_valid !== 1'b0) begin failures++; $display("FAIL post_reset_plain flags=%b vld=%b exp=00000/0", flags, ascii_valid); end
    // Reset wins over a simultaneous byte.
    reset = 1'b1;
    send_byte(8'h1C);
    reset = 1'b0;
    checks++; if (ascii !== 8'h00 || ascii_valid !== 1'b0) begin failures++; $display("FAIL reset_priority ascii=%h vld=%b exp=00/0", ascii, ascii_valid); end
  endtask

  task automatic test_stray_brk;
    send_byte(8'h32);
    checks++; if (ascii !== 8'h62) begin failures++; $display("FAIL stray_setup got=%h exp=62", ascii); end
    send_byte(8'hF0); send_byte(8'hF0);
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL stray_discard got=%b exp=0", ascii_valid); end
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h61 || ascii_valid !== 1'b1) begin failures++; $display("FAIL stray_recover ascii=%h vld=%b exp=61/1", ascii, ascii_valid); end
  endtask

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    test_reset;
    test_ext_arrow;
    test_ascii_shift;
    test_ascii_table;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_stray_brk;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
